// File: rtl/id_stage.sv
// id_stage: instruction decode stage.
// Owns the general register file and decodes 16-bit instruction words.
// Pairs each I-type word with the immediate word that follows it.
// Detects load-use hazards and drives the registered ID/EX payload.
module id_stage #(
    parameter int         NREGS     = 8,
    parameter logic [3:0] IMM_OPC   = 4'd8,
    parameter logic [3:0] LOAD_OPC  = 4'd9,
    parameter logic [3:0] STORE_OPC = 4'd10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic [15:0] instruction,
    input  logic [15:0] data,
    input  logic        int_in,
    input  logic        wb_en,
    input  logic [2:0]  wb_addr,
    input  logic [15:0] wb_data,
    input  logic        stall_in,
    input  logic        flush,
    output logic        hazard_stall,
    output logic [31:0] ex_pc,
    output logic [15:0] ex_op1,
    output logic [15:0] ex_op2,
    output logic [15:0] ex_imm,
    output logic [2:0]  ex_rdst,
    output logic [2:0]  ex_rsrc1,
    output logic [2:0]  ex_rsrc2,
    output logic [3:0]  ex_opcode,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_use_imm,
    output logic        ex_int
);

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_IMM = 1'b1
    } state_t;

    // ID/EX payload; an all-zero value is a bubble.
    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [15:0] imm;
        logic [2:0]  rdst;
        logic [2:0]  rsrc1;
        logic [2:0]  rsrc2;
        logic [3:0]  opcode;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        use_imm;
        logic        intr;
    } idex_t;

    // I-type word waiting for its immediate; its opcode is always IMM_OPC.
    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  rdst;
        logic [2:0]  rsrc1;
        logic [2:0]  rsrc2;
    } pend_t;

    state_t      r_state;
    pend_t       r_pend;
    idex_t       r_idex;
    logic [15:0] r_regs [NREGS];

    logic [3:0]  w_opcode;
    logic [2:0]  w_rdst;
    logic [2:0]  w_rsrc1;
    logic [2:0]  w_rsrc2;
    logic        w_is_alu;
    logic        w_dec_reg_write;
    logic        w_dec_mem_read;
    logic        w_dec_mem_write;
    logic        w_use_rsrc1;
    logic        w_use_rsrc2;
    logic        w_load_use;
    logic [2:0]  w_rd_idx1;
    logic [2:0]  w_rd_idx2;
    logic [15:0] w_rd_data1;
    logic [15:0] w_rd_data2;
    idex_t       w_direct;
    idex_t       w_pend_issue;
    logic        w_unused;

    // The low three bits of the instruction word carry no field.
    assign w_unused = ^instruction[2:0];

    // Extract the effective word's fields; an interrupt-marked word decodes as a NOP.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        w_opcode = 4'd0;
        w_rdst   = 3'd0;
        w_rsrc1  = 3'd0;
        w_rsrc2  = 3'd0;
        if (!int_in) begin
            w_opcode = instruction[15:12];
            w_rdst   = instruction[11:9];
            w_rsrc1  = instruction[8:6];
            w_rsrc2  = instruction[5:3];
        end
    end

    // Decode the control bits and which source registers the word really reads.
    always_comb begin
        w_is_alu        = (w_opcode != 4'd0) && (w_opcode <= 4'd7);
        w_dec_reg_write = w_is_alu || (w_opcode == IMM_OPC) || (w_opcode == LOAD_OPC);
        w_dec_mem_read  = (w_opcode == LOAD_OPC);
        w_dec_mem_write = (w_opcode == STORE_OPC);
        w_use_rsrc1     = w_is_alu || (w_opcode == STORE_OPC)
                          || (w_opcode == IMM_OPC) || (w_opcode == LOAD_OPC);
        w_use_rsrc2     = w_is_alu || (w_opcode == STORE_OPC);
    end

    // Load-use detection: a load in ID/EX whose destination the current word reads.
    always_comb begin
        w_load_use   = (r_state == S_IDLE) && r_idex.mem_read
                       && ((w_use_rsrc1 && (r_idex.rdst == w_rsrc1))
                        || (w_use_rsrc2 && (r_idex.rdst == w_rsrc2)));
        hazard_stall = w_load_use && !reset && !flush && !stall_in;
    end

    // Register read ports; the pending word's sources are read while waiting for its immediate.
    always_comb begin
        w_rd_idx1  = (r_state == S_WAIT_IMM) ? r_pend.rsrc1 : w_rsrc1;
        w_rd_idx2  = (r_state == S_WAIT_IMM) ? r_pend.rsrc2 : w_rsrc2;
        w_rd_data1 = (wb_en && (wb_addr == w_rd_idx1)) ? wb_data : r_regs[w_rd_idx1];
        w_rd_data2 = (wb_en && (wb_addr == w_rd_idx2)) ? wb_data : r_regs[w_rd_idx2];
    end

    // Build the two candidate ID/EX payloads: direct issue and pending I-type issue.
    always_comb begin
        w_direct           = '0;
        w_direct.pc        = pc_in;
        w_direct.op1       = w_rd_data1;
        w_direct.op2       = w_rd_data2;
        w_direct.rdst      = w_rdst;
        w_direct.rsrc1     = w_rsrc1;
        w_direct.rsrc2     = w_rsrc2;
        w_direct.opcode    = w_opcode;
        w_direct.reg_write = w_dec_reg_write;
        w_direct.mem_read  = w_dec_mem_read;
        w_direct.mem_write = w_dec_mem_write;
        w_direct.intr      = int_in;

        w_pend_issue           = '0;
        w_pend_issue.pc        = r_pend.pc;
        w_pend_issue.op1       = w_rd_data1;
        w_pend_issue.op2       = w_rd_data2;
        w_pend_issue.imm       = data;
        w_pend_issue.rdst      = r_pend.rdst;
        w_pend_issue.rsrc1     = r_pend.rsrc1;
        w_pend_issue.rsrc2     = r_pend.rsrc2;
        w_pend_issue.opcode    = IMM_OPC;
        w_pend_issue.reg_write = 1'b1;
        w_pend_issue.use_imm   = 1'b1;
    end

    // Register file: cleared on reset, otherwise written by writeback even during flush or stall.
    always_ff @(posedge clk) begin
        // NOTE: this array is reset explicitly, which keeps it in flops; an array without reset could map to RAM.
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= 16'd0;
            end
        end else if (wb_en) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // Decode FSM and ID/EX register: reset > flush > stall > hazard > normal issue.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments, so every flop samples pre-edge values regardless of statement order.
        if (reset) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
            r_idex  <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
            r_idex  <= '0;
        end else if (stall_in) begin
            r_state <= r_state;
            r_pend  <= r_pend;
            r_idex  <= r_idex;
        end else if (r_state == S_WAIT_IMM) begin
            r_state <= S_IDLE;
            r_idex  <= w_pend_issue;
        end else if (w_load_use) begin
            r_idex  <= '0;
        end else if (w_opcode == IMM_OPC) begin
            r_state      <= S_WAIT_IMM;
            r_pend.pc    <= pc_in;
            r_pend.rdst  <= w_rdst;
            r_pend.rsrc1 <= w_rsrc1;
            r_pend.rsrc2 <= w_rsrc2;
            r_idex       <= '0;
        end else begin
            r_idex <= w_direct;
        end
    end

    assign ex_pc        = r_idex.pc;
    assign ex_op1       = r_idex.op1;
    assign ex_op2       = r_idex.op2;
    assign ex_imm       = r_idex.imm;
    assign ex_rdst      = r_idex.rdst;
    assign ex_rsrc1     = r_idex.rsrc1;
    assign ex_rsrc2     = r_idex.rsrc2;
    assign ex_opcode    = r_idex.opcode;
    assign ex_reg_write = r_idex.reg_write;
    assign ex_mem_read  = r_idex.mem_read;
    assign ex_mem_write = r_idex.mem_write;
    assign ex_use_imm   = r_idex.use_imm;
    assign ex_int       = r_idex.intr;

endmodule

// File: doc/id_stage.md
# id_stage

Instruction decode stage. It sits between the fetch stage's IF/ID buffer and the execute stage, and owns the 8×16 general register file. It decodes each 16-bit word, reads operands, pairs an I-type opcode word with the immediate word that follows it, and detects load-use hazards. Results go out through an internal ID/EX pipeline register.

## Interface
- NREGS, 8: number of general registers (register index width is 3 bits).
- IMM_OPC, 4'd8: opcode of I-type instructions; these take a second, immediate word.
- LOAD_OPC, 4'd9: opcode of the load instruction (mem_read).
- STORE_OPC, 4'd10: opcode of the store instruction (mem_write).
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- pc_in  in  32  PC from the IF/ID buffer.
- instruction  in  16  opcode[15:12], rdst[11:9], rsrc1[8:6], rsrc2[5:3]; 16'd0 is a NOP.
- data  in  16  immediate word; valid in the cycle after an I-type word.
- int_in  in  1  interrupt marker from fetch.
- wb_en  in  1  register-file write enable from writeback.
- wb_addr  in  3  writeback register index.
- wb_data  in  16  writeback value.
- stall_in  in  1  downstream stall; hold all state.
- flush  in  1  squash the ID/EX contents and any pending I-type word.
- hazard_stall  out  1  combinational; stalls PC and the IF/ID buffer.
- ex_pc, ex_op1, ex_op2, ex_imm  out  32/16/16/16  ID/EX payload.
- ex_rdst, ex_rsrc1, ex_rsrc2  out  3 each  register indices for forwarding.
- ex_opcode  out  4  operation code.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_use_imm, ex_int  out  1 each  control bits.

## Operation
- Register file:
  - NREGS×16; a write on posedge when wb_en=1.
  - Read bypass: if wb_en=1 and wb_addr matches a source index, that read returns wb_data in the same cycle.
- Decode classes:
  - opcode 0: NOP; all control bits 0.
  - opcodes 1–7: ALU; reg_write=1.
  - IMM_OPC: reg_write=1, use_imm=1.
  - LOAD_OPC: mem_read=1, reg_write=1.
  - STORE_OPC: mem_write=1.
  - opcodes 11–15: control bits 0; opcode passed through for the execute stage.
- FSM states are IDLE and WAIT_IMM.
  - IDLE with an I-type word: latch the decoded word into a pending register, go to WAIT_IMM, and issue a bubble to ID/EX.
  - WAIT_IMM: the instruction input is ignored (fetch drives 0). Issue the pending word with ex_imm=data and operands read this cycle, then return to IDLE.
  - Any other word in IDLE issues directly, with ex_imm=16'd0.
- Load-use hazard:
  - hazard_stall=1 when ex_mem_read=1, ex_rdst equals a source the current word actually uses, and the state is IDLE.
  - Sources used: ALU and store use rsrc1 and rsrc2; IMM_OPC and LOAD_OPC use rsrc1 only; NOP and opcodes 11–15 use none.
  - While hazard_stall=1, ID/EX loads a bubble and the current word is re-presented next cycle.
- Bubble: all ex_* control bits and ex_opcode are 0; the payload is don't-care but driven to 0.
- ex_int copies int_in on issue. The cycle int_in=1 arrives, the word itself is treated as a NOP.

## Timing
- Latency: one cycle from IF/ID to ID/EX for normal words. An I-type instruction issues two cycles after its opcode word (one bubble first).
- Reset:
  - All registers and every ex_* output go to 0; FSM to IDLE; the pending register is cleared.
  - hazard_stall=0 after reset.
  - Reset wins over flush, stall_in and wb_en in the same cycle.
- Priority: reset > flush > stall_in > hazard_stall > normal.
- flush=1: ID/EX gets a bubble and FSM goes to IDLE. The register-file write still happens.
- stall_in=1:
  - ID/EX, the FSM and the pending register hold.
  - Register-file writes still occur.
  - hazard_stall is forced to 0.
- Reset mid-WAIT_IMM: the pending word is discarded and no issue occurs.
- A hazard never asserts in WAIT_IMM; the immediate word has no sources.

## Test plan
- Reset, then ADD R3,R1,R2 with R1=5, R2=7 written via WB earlier -> next cycle ex_op1=5, ex_op2=7, ex_rdst=3, ex_reg_write=1.
- I-type word (opcode 8, rdst=4), then instruction=0 with data=16'h1234 -> one bubble cycle, then ex_use_imm=1, ex_imm=16'h1234, ex_rdst=4.
- LOAD R2 issued, followed by ADD R5,R2,R1 -> hazard_stall=1 for exactly one cycle, one bubble in ID/EX, then the ADD issues.
- wb_en=1, wb_addr=1, wb_data=16'hBEEF in the same cycle as decoding a word that reads R1 -> ex_op1=16'hBEEF.
- flush during WAIT_IMM -> bubble, FSM back to IDLE; the next data word is not issued as an immediate.
- stall_in held 3 cycles with a valid word in ID/EX -> ex_* unchanged throughout, then normal issue resumes.
